// File: rtl/hex_pkg.sv
// Shared ASCII-hex helpers: character constants, receive FSM states and
// the byte-to-nibble decoder used by both the hex receiver and printers.
package hex_pkg;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Returns {is_hex, nibble}; nibble is zero for non-hex bytes.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        logic [7:0] t;
        logic [4:0] r;
        r = '0;
        t = '0;
        unique case (1'b1)
            (c >= 8'h30 && c <= 8'h39): begin
                t = c - 8'h30;
                r = {1'b1, t[3:0]};
            end
            (c >= 8'h61 && c <= 8'h66): begin
                t = c - 8'h57;
                r = {1'b1, t[3:0]};
            end
            (c >= 8'h41 && c <= 8'h46): begin
                t = c - 8'h37;
                r = {1'b1, t[3:0]};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hex_char_class.sv
// Combinational byte classifier: hex digit, word terminator, or neither.
module hex_char_class
    import hex_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic       is_term,
    output logic [3:0] nibble
);

    logic [4:0] dec;

    always_comb begin
        dec     = hex_nibble(ch);
        is_hex  = dec[4];
        nibble  = dec[3:0];
        is_term = (ch == CHAR_LF) || (ch == CHAR_CR) || (ch == CHAR_SP);
    end

endmodule

// File: rtl/hex_word_rx.sv
// ASCII-hex word receiver: assembles hex digits from the UART byte stream
// into a WIDTH-bit word and offers it on a valid/ready port at a terminator.
module hex_word_rx
    import hex_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       rxd,
    input  logic             rxd_strobe,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             err_char,
    output logic             err_overrun
);

    localparam int NDIG = WIDTH / 4;
    localparam int DW   = $clog2(NDIG + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DW-1:0] DMAX = DW'(NDIG);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [DW-1:0]     ndig_q, ndig_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              valid_q, valid_d;
    logic              err_char_q, err_char_d;
    logic              err_ovr_q, err_ovr_d;

    logic              is_hex;
    logic              is_term;
    logic [3:0]        nibble;

    hex_char_class u_class (
        .ch      (rxd),
        .is_hex  (is_hex),
        .is_term (is_term),
        .nibble  (nibble)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ndig_d     = ndig_q;
        timer_d    = timer_q;
        word_d     = word_q;
        valid_d    = valid_q;
        err_char_d = 1'b0;
        err_ovr_d  = 1'b0;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        if (rxd_strobe) begin
            timer_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (is_hex) begin
                        acc_d   = WIDTH'(nibble);
                        ndig_d  = DW'(1);
                        state_d = S_ACCUM;
                    end else if (!is_term) begin
                        err_char_d = 1'b1;
                        state_d    = S_DISCARD;
                    end
                end
                S_ACCUM: begin
                    if (is_hex && ndig_q < DMAX) begin
                        acc_d  = (acc_q << 4) | WIDTH'(nibble);
                        ndig_d = ndig_q + DW'(1);
                    end else if (is_term) begin
                        // Emit succeeds if the slot is free or drains this cycle.
                        if (!valid_q || word_ready) begin
                            word_d  = acc_q;
                            valid_d = 1'b1;
                        end else begin
                            err_ovr_d = 1'b1;
                        end
                        ndig_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        err_char_d = 1'b1;
                        state_d    = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_term) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (TIMEOUT > 0 && state_q != S_IDLE) begin
            if (timer_q == TMAX) begin
                state_d = S_IDLE;
                acc_d   = '0;
                ndig_d  = '0;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            ndig_q     <= '0;
            timer_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            err_char_q <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ndig_q     <= ndig_d;
            timer_q    <= timer_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            err_char_q <= err_char_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    assign word        = word_q;
    assign word_valid  = valid_q;
    assign err_char    = err_char_q;
    assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_hex_word_rx.sv
// Scoreboard bench for hex_word_rx: directed byte strings, expected words
// queued at stimulus time and popped by an independent output monitor.
module tb_hex_word_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        rxd_strobe = 1'b0;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        err_char;
    logic        err_overrun;

    int n_pass = 0;
    int n_total = 0;
    int exp_char = 0;
    int exp_ovr = 0;
    int got_char = 0;
    int got_ovr = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hex_word_rx #(.WIDTH(32), .TIMEOUT(100)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxd         (rxd),
        .rxd_strobe  (rxd_strobe),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .err_char    (err_char),
        .err_overrun (err_overrun)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rxd = b;
        rxd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rxd_strobe = 1'b0;
    endtask

    task automatic gap();
        repeat (39) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            gap();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Output monitor: runs on the falling edge, away from the active edge.
    logic        prev_char = 1'b0;
    logic        prev_ovr = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_word = '0;
    logic [31:0] exp_w;

    always @(negedge clk) begin
        if (reset_n) begin
            if (err_char) got_char++;
            if (err_overrun) got_ovr++;
            if (err_char && prev_char) check("err_char_width", 32'd2, 32'd1);
            if (err_overrun && prev_ovr) check("err_ovr_width", 32'd2, 32'd1);
            if (err_char && err_overrun) check("err_both", 32'd1, 32'd0);
            if (prev_hold && word_valid) check("word_stable", word, prev_word);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", word, 32'hxxxxxxxx);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", word, exp_w);
                end
            end
        end
        prev_char = err_char;
        prev_ovr  = err_overrun;
        prev_hold = word_valid && !word_ready;
        prev_word = word;
    end

    task automatic check_errs(input string tag);
        check({tag, "_err_char"}, 32'(got_char), 32'(exp_char));
        check({tag, "_err_ovr"}, 32'(got_ovr), 32'(exp_ovr));
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        idle(3);
        #1;
        check("rst_word", word, 32'h0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_errs", {30'd0, err_char, err_overrun}, 32'd0);
        reset_n = 1'b1;
        idle(3);

        // Full-width word, one cycle latency after the terminator.
        send_str("DEADbeef");
        exp_q.push_back(32'hDEADBEEF);
        send(8'h0A);
        check("latency_valid", 32'(word_valid), 32'd1);
        check("latency_word", word, 32'hDEADBEEF);
        gap();
        check_errs("t1");

        // CRLF: second terminator emits nothing.
        exp_q.push_back(32'h0000001F);
        send_str("1f\r\n");
        check_errs("t2");

        // Bad character discards the line.
        exp_char++;
        exp_q.push_back(32'h00000007);
        send_str("12x4\n7\n");
        check_errs("t3");

        // Ninth digit overflows.
        exp_char++;
        send_str("123456789\n");
        exp_q.push_back(32'h00000005);
        send_str("5\n");
        check_errs("t4");

        // Output busy: second word dropped with an overrun pulse.
        word_ready = 1'b0;
        exp_q.push_back(32'h0000000A);
        exp_ovr++;
        send_str("A\nB\n");
        #1;
        check("held_valid", 32'(word_valid), 32'd1);
        check("held_word", word, 32'h0000000A);
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        idle(3);
        #1;
        check("drained_valid", 32'(word_valid), 32'd0);
        check_errs("t5");

        // Idle timeout drops the partial word.
        send_str("AB");
        idle(100);
        exp_q.push_back(32'h0000000C);
        send_str("C\n");
        check_errs("t6");

        // Reset mid-word with a held output.
        word_ready = 1'b0;
        send_str("9\n");
        check("pre_rst_valid", 32'(word_valid), 32'd1);
        send_str("12");
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_word", word, 32'h0);
        idle(2);
        #1;
        reset_n = 1'b1;
        word_ready = 1'b1;
        idle(2);
        exp_q.push_back(32'h00000003);
        send_str("\n3\n");
        check_errs("t7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
